// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the modulo counter
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HELD = 2'b01,
        DONE = 2'b10
    } state_t;

    // Modes that stop at the terminal value instead of wrapping; 2'b11 falls back to wrap.
    function automatic logic is_stop_mode(input logic [1:0] mode);
        return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/bus_driver.sv
// rtl/bus_driver.sv - oe-gated tristate driver for the shared data bus
module bus_driver #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] data,
    output wire  [WIDTH-1:0] bus
);

    assign bus = oe ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with wrap/saturate/one-shot end-of-count
module mod_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    input  logic             oe,
    output wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             held,
    output logic             done
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t           state;
    logic             held_up;
    logic             terminal;
    logic [WIDTH-1:0] load_clamped;

    assign terminal     = down ? (count == '0) : (count >= limit);
    assign load_clamped = (load_val > limit) ? limit : load_val;

    assign held = (state == HELD);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= RESET_COUNT;
            state   <= RUN;
            tc      <= 1'b0;
            held_up <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= load_clamped;
                state <= RUN;
            end else if (en) begin
                case (state)
                    RUN: begin
                        if (!terminal) begin
                            count <= down ? count - ONE : count + ONE;
                        end else begin
                            tc <= 1'b1;
                            if (is_stop_mode(mode)) begin
                                // An up-count above a lowered limit clamps down to it.
                                if (!down && count > limit)
                                    count <= limit;
                                state   <= (mode == MODE_SAT) ? HELD : DONE;
                                held_up <= !down;
                            end else begin
                                count <= down ? limit : '0;
                            end
                        end
                    end
                    HELD: begin
                        // Only a reversal away from the held end restarts counting.
                        if (down == held_up) begin
                            state <= RUN;
                            if (held_up) begin
                                if (count != '0)
                                    count <= count - ONE;
                            end else if (count < limit) begin
                                count <= count + ONE;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= RUN;
                endcase
            end
        end
    end

    bus_driver #(.WIDTH(WIDTH)) u_bus_driver (
        .oe   (oe),
        .data (count),
        .bus  (bus)
    );

endmodule
